// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and the instruction memory.
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              Mem_req;
  logic [ADDR_W-1:0] Mem_addr;
  logic              Mem_gnt;
  logic              Mem_rvalid;
  logic [DATA_W-1:0] Mem_rdata;

  modport master (
    output Mem_req,
    output Mem_addr,
    input  Mem_gnt,
    input  Mem_rvalid,
    input  Mem_rdata
  );

  modport slave (
    input  Mem_req,
    input  Mem_addr,
    output Mem_gnt,
    output Mem_rvalid,
    output Mem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one memory request per PC, IF/ID output register with a
// one-entry skid buffer, next-PC selection with branch redirect and wrong-path drain.
module fetch_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Pc_in,
  output logic [ADDR_W-1:0] Next_pc,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] Branch_target,
  fetch_ctrl_if.master      mem,
  input  logic              Stall,
  output logic              Ifid_valid,
  output logic [DATA_W-1:0] Ifid_instr,
  output logic [ADDR_W-1:0] Ifid_pc
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t            state, state_n;
  logic              ifid_valid_n;
  logic [DATA_W-1:0] ifid_instr_n;
  logic [ADDR_W-1:0] ifid_pc_n;
  // Skid contents are meaningful only while in HOLD.
  logic [DATA_W-1:0] skid_instr, skid_instr_n;
  logic [ADDR_W-1:0] skid_pc, skid_pc_n;

  logic [ADDR_W-1:0] pc_aligned;
  logic [ADDR_W-1:0] target_aligned;
  logic              out_free;

  assign pc_aligned     = {Pc_in[ADDR_W-1:2], 2'b00};
  assign target_aligned = {Branch_target[ADDR_W-1:2], 2'b00};
  assign out_free       = !Ifid_valid || !Stall;

  assign mem.Mem_req  = (state == FETCH);
  assign mem.Mem_addr = Pc_in;

  // State and output registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      Ifid_valid <= 1'b0;
      Ifid_instr <= '0;
      Ifid_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      state      <= state_n;
      Ifid_valid <= ifid_valid_n;
      Ifid_instr <= ifid_instr_n;
      Ifid_pc    <= ifid_pc_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
    end
  end

  // Next-state, next-PC and IF/ID update
  always_comb begin
    state_n      = state;
    ifid_valid_n = Ifid_valid && Stall;
    ifid_instr_n = Ifid_instr;
    ifid_pc_n    = Ifid_pc;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    Next_pc      = Pc_in;

    unique case (state)
      IDLE:  state_n = FETCH;
      FETCH: if (mem.Mem_gnt) state_n = WAIT;
      WAIT: begin
        if (mem.Mem_rvalid) begin
          Next_pc = Pc_in + ADDR_W'(4);
          if (out_free) begin
            ifid_valid_n = 1'b1;
            ifid_instr_n = mem.Mem_rdata;
            ifid_pc_n    = pc_aligned;
            state_n      = FETCH;
          end else begin
            skid_instr_n = mem.Mem_rdata;
            skid_pc_n    = pc_aligned;
            state_n      = HOLD;
          end
        end
      end
      HOLD: begin
        if (!Stall) begin
          ifid_valid_n = 1'b1;
          ifid_instr_n = skid_instr;
          ifid_pc_n    = skid_pc;
          state_n      = FETCH;
        end
      end
      DRAIN: if (mem.Mem_rvalid) state_n = FETCH;
      default: state_n = IDLE;
    endcase

    // Redirect wins over everything; an outstanding request must be drained first.
    if (Branch_taken) begin
      Next_pc      = target_aligned;
      ifid_valid_n = 1'b0;
      ifid_instr_n = Ifid_instr;
      ifid_pc_n    = Ifid_pc;
      unique case (state)
        FETCH:        state_n = mem.Mem_gnt    ? DRAIN : FETCH;
        WAIT, DRAIN:  state_n = mem.Mem_rvalid ? FETCH : DRAIN;
        default:      state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus a hand-written async reset sequence.
module tb_fetch_ctrl;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] Next_pc;
  logic              Branch_taken;
  logic [ADDR_W-1:0] Branch_target;
  logic              Stall;
  logic              Ifid_valid;
  logic [DATA_W-1:0] Ifid_instr;
  logic [ADDR_W-1:0] Ifid_pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Pc_in         (pc_reg),
    .Next_pc       (Next_pc),
    .Branch_taken  (Branch_taken),
    .Branch_target (Branch_target),
    .mem           (mem_bus.master),
    .Stall         (Stall),
    .Ifid_valid    (Ifid_valid),
    .Ifid_instr    (Ifid_instr),
    .Ifid_pc       (Ifid_pc)
  );

  always #5 Clock = ~Clock;

  // External PC register fed by Next_pc
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) pc_reg <= '0;
    else       pc_reg <= Next_pc;
  end

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        st;
    logic        req;
    logic [31:0] addr;
    logic [31:0] npc;
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic br, input logic [31:0] tgt, input logic gnt,
                              input logic rv, input logic [31:0] rd, input logic st,
                              input logic req, input logic [31:0] addr, input logic [31:0] npc,
                              input logic v, input logic [31:0] ins, input logic [31:0] pc);
    vec_t r;
    r = '{br, tgt, gnt, rv, rd, st, req, addr, npc, v, ins, pc};
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    Branch_taken          = 1'b0;
    Branch_target         = '0;
    Stall                 = 1'b0;
    mem_bus.Mem_gnt       = 1'b0;
    mem_bus.Mem_rvalid    = 1'b0;
    mem_bus.Mem_rdata     = '0;
  endtask

  initial begin
    //   br tgt          gnt rv rdata        st | req addr        npc          v  instr        pc
    add(0, 0,            0, 0, 0,            0,  0, 0,           0,           0, 0,           0);
    add(0, 0,            1, 0, 0,            0,  1, 0,           0,           0, 0,           0);
    add(0, 0,            0, 1, 32'h20080005, 0,  0, 0,           4,           0, 0,           0);
    add(0, 0,            0, 0, 0,            0,  1, 4,           4,           1, 32'h20080005, 0);
    add(0, 0,            1, 0, 0,            0,  1, 4,           4,           0, 0,           0);
    add(0, 0,            0, 0, 0,            0,  0, 0,           4,           0, 0,           0);
    add(0, 0,            0, 1, 32'hA1A1A1A1, 0,  0, 0,           8,           0, 0,           0);
    add(0, 0,            0, 0, 0,            0,  1, 8,           8,           1, 32'hA1A1A1A1, 4);
    add(0, 0,            1, 0, 0,            0,  1, 8,           8,           0, 0,           0);
    add(0, 0,            0, 0, 0,            0,  0, 0,           8,           0, 0,           0);
    add(0, 0,            0, 1, 32'hA2A2A2A2, 0,  0, 0,           12,          0, 0,           0);
    add(0, 0,            0, 0, 0,            0,  1, 12,          12,          1, 32'hA2A2A2A2, 8);
    add(0, 0,            1, 0, 0,            0,  1, 12,          12,          0, 0,           0);
    add(0, 0,            0, 0, 0,            0,  0, 0,           12,          0, 0,           0);
    add(0, 0,            0, 1, 32'hA3A3A3A3, 0,  0, 0,           16,          0, 0,           0);
    // stall with a valid entry; response lands in the skid buffer
    add(0, 0,            1, 0, 0,            1,  1, 16,          16,          1, 32'hA3A3A3A3, 12);
    add(0, 0,            0, 0, 0,            1,  0, 0,           16,          1, 32'hA3A3A3A3, 12);
    add(0, 0,            0, 1, 32'hA4A4A4A4, 1,  0, 0,           20,          1, 32'hA3A3A3A3, 12);
    add(0, 0,            0, 0, 0,            1,  0, 0,           20,          1, 32'hA3A3A3A3, 12);
    add(0, 0,            0, 0, 0,            1,  0, 0,           20,          1, 32'hA3A3A3A3, 12);
    add(0, 0,            0, 0, 0,            1,  0, 0,           20,          1, 32'hA3A3A3A3, 12);
    add(0, 0,            0, 0, 0,            0,  0, 0,           20,          1, 32'hA3A3A3A3, 12);
    add(0, 0,            1, 0, 0,            0,  1, 20,          20,          1, 32'hA4A4A4A4, 16);
    // redirect in WAIT, wrong-path word drained
    add(1, 32'h43,       0, 0, 0,            0,  0, 0,           32'h40,      0, 0,           0);
    add(0, 0,            0, 0, 0,            0,  0, 0,           32'h40,      0, 0,           0);
    add(0, 0,            0, 1, 32'hDEADBEEF, 0,  0, 0,           32'h40,      0, 0,           0);
    add(0, 0,            1, 0, 0,            0,  1, 32'h40,      32'h40,      0, 0,           0);
    add(0, 0,            0, 1, 32'hB0B0B0B0, 0,  0, 0,           32'h44,      0, 0,           0);
    add(0, 0,            1, 0, 0,            0,  1, 32'h44,      32'h44,      1, 32'hB0B0B0B0, 32'h40);
    add(0, 0,            0, 1, 32'hB1B1B1B1, 0,  0, 0,           32'h48,      0, 0,           0);
    // redirect in FETCH with grant while stalled: flush and drain
    add(1, 32'h100,      1, 0, 0,            1,  1, 32'h48,      32'h100,     1, 32'hB1B1B1B1, 32'h44);
    add(0, 0,            0, 0, 0,            1,  0, 0,           32'h100,     0, 0,           0);
    add(0, 0,            0, 1, 32'h0BADBAD0, 0,  0, 0,           32'h100,     0, 0,           0);
    add(0, 0,            0, 0, 0,            0,  1, 32'h100,     32'h100,     0, 0,           0);
    add(0, 0,            1, 0, 0,            0,  1, 32'h100,     32'h100,     0, 0,           0);
    // redirect coinciding with rvalid: discard, no drain
    add(1, 32'h200,      0, 1, 32'h0BADBAD1, 0,  0, 0,           32'h200,     0, 0,           0);
    add(0, 0,            0, 0, 0,            0,  1, 32'h200,     32'h200,     0, 0,           0);
    add(0, 0,            1, 0, 0,            0,  1, 32'h200,     32'h200,     0, 0,           0);
    add(0, 0,            0, 1, 32'hC0C0C0C0, 0,  0, 0,           32'h204,     0, 0,           0);
    add(0, 0,            0, 0, 0,            0,  1, 32'h204,     32'h204,     1, 32'hC0C0C0C0, 32'h200);
    // wrap-around at the top of the address space
    add(1, 32'hFFFFFFFF, 0, 0, 0,            0,  1, 32'h204,     32'hFFFFFFFC, 0, 0,           0);
    add(0, 0,            1, 0, 0,            0,  1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0,          0);
    add(0, 0,            0, 1, 32'hC1C1C1C1, 0,  0, 0,           0,           0, 0,           0);
    add(0, 0,            1, 0, 0,            1,  1, 0,           0,           1, 32'hC1C1C1C1, 32'hFFFFFFFC);

    drive_idle();
    Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    chk("reset_valid", 32'(Ifid_valid), 0);
    chk("reset_instr", Ifid_instr, 0);
    chk("reset_pc",    Ifid_pc, 0);
    chk("reset_req",   32'(mem_bus.Mem_req), 0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      Branch_taken       = vecs[i].br;
      Branch_target      = vecs[i].tgt;
      mem_bus.Mem_gnt    = vecs[i].gnt;
      mem_bus.Mem_rvalid = vecs[i].rv;
      mem_bus.Mem_rdata  = vecs[i].rd;
      Stall              = vecs[i].st;
      #1;
      chk($sformatf("v%0d_req", i),   32'(mem_bus.Mem_req), 32'(vecs[i].req));
      chk($sformatf("v%0d_npc", i),   Next_pc, vecs[i].npc);
      chk($sformatf("v%0d_valid", i), 32'(Ifid_valid), 32'(vecs[i].v));
      if (vecs[i].req) chk($sformatf("v%0d_addr", i), mem_bus.Mem_addr, vecs[i].addr);
      if (vecs[i].v) begin
        chk($sformatf("v%0d_instr", i),  Ifid_instr, vecs[i].ins);
        chk($sformatf("v%0d_ifidpc", i), Ifid_pc, vecs[i].pc);
      end
      @(negedge Clock);
    end

    // Async reset between edges while in WAIT with a stalled valid entry
    drive_idle();
    Stall = 1'b1;
    #1;
    chk("mid_valid_before", 32'(Ifid_valid), 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_valid_async", 32'(Ifid_valid), 0);
    chk("mid_req_async",   32'(mem_bus.Mem_req), 0);
    chk("mid_pc_async",    Ifid_pc, 0);
    chk("mid_instr_async", Ifid_instr, 0);
    @(negedge Clock);
    Reset = 1'b0;
    Stall = 1'b0;
    #1;
    chk("post_idle_req", 32'(mem_bus.Mem_req), 0);
    chk("post_idle_npc", Next_pc, 0);
    @(negedge Clock);
    #1;
    chk("post_fetch_req",  32'(mem_bus.Mem_req), 1);
    chk("post_fetch_addr", mem_bus.Mem_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
